// File: rtl/axi4_sram_if.sv
// AXI4 channel bundle between a burst master and the SRAM responder.
// Carries the AW/W/B/AR/R signals; the slave modport is used by the responder.
interface axi4_sram_if #(
   parameter int DATA_WIDTH = 512,
   parameter int ID_WIDTH   = 4
);
   logic                    aw_valid;
   logic                    aw_ready;
   logic [ID_WIDTH-1:0]     aw_id;
   logic [31:0]             aw_addr;
   logic [7:0]              aw_len;
   logic [2:0]              aw_size;
   logic [1:0]              aw_burst;

   logic                    w_valid;
   logic                    w_ready;
   logic [DATA_WIDTH-1:0]   w_data;
   logic [DATA_WIDTH/8-1:0] w_strb;
   logic                    w_last;

   logic                    b_valid;
   logic                    b_ready;
   logic [ID_WIDTH-1:0]     b_id;
   logic [1:0]              b_resp;

   logic                    ar_valid;
   logic                    ar_ready;
   logic [ID_WIDTH-1:0]     ar_id;
   logic [31:0]             ar_addr;
   logic [7:0]              ar_len;
   logic [2:0]              ar_size;
   logic [1:0]              ar_burst;

   logic                    r_valid;
   logic                    r_ready;
   logic [ID_WIDTH-1:0]     r_id;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [1:0]              r_resp;
   logic                    r_last;

   modport master (
      output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
      input  aw_ready,
      output w_valid, w_data, w_strb, w_last,
      input  w_ready,
      input  b_valid, b_id, b_resp,
      output b_ready,
      output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
      input  ar_ready,
      input  r_valid, r_id, r_data, r_resp, r_last,
      output r_ready
   );

   modport slave (
      input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
      output aw_ready,
      input  w_valid, w_data, w_strb, w_last,
      output w_ready,
      output b_valid, b_id, b_resp,
      input  b_ready,
      input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
      output ar_ready,
      output r_valid, r_id, r_data, r_resp, r_last,
      input  r_ready
   );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 responder backed by a word array; one write and one read burst
// in flight at once, each run by its own channel FSM.
module axi4_sram_slave #(
   parameter int          DATA_WIDTH = 512,
   parameter int          ID_WIDTH   = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter int          MEM_WORDS  = 1024
) (
   input logic        aclk,
   input logic        aresetn,
   axi4_sram_if.slave axi
);
   localparam int NB  = DATA_WIDTH / 8;
   localparam int WSH = $clog2(NB);
   localparam int IW  = $clog2(MEM_WORDS);
   localparam logic [32:0] LIMIT =
      {1'b0, BASE_ADDR} + 33'(MEM_WORDS * NB);

   localparam logic [1:0] B_FIXED = 2'b00;
   localparam logic [1:0] B_INCR  = 2'b01;
   localparam logic [1:0] OKAY    = 2'b00;
   localparam logic [1:0] SLVERR  = 2'b10;
   localparam logic [1:0] DECERR  = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_st_t;
   typedef enum logic       {R_IDLE, R_DATA} r_st_t;

   function automatic logic [31:0] f_align(
      input logic [31:0] a, input logic [2:0] s);
      return a & ~((32'd1 << s) - 32'd1);
   endfunction

   function automatic logic [31:0] f_next(
      input logic [31:0] a, input logic [2:0] s,
      input logic [1:0] b);
      return (b == B_INCR) ? a + (32'd1 << s) : a;
   endfunction

   function automatic logic [IW-1:0] f_idx(input logic [31:0] a);
      return IW'((a - BASE_ADDR) >> WSH);
   endfunction

   // Whole-burst decode: burst type first, then first/last beat range.
   function automatic logic [1:0] f_chk(
      input logic [31:0] a, input logic [7:0] l,
      input logic [2:0] s, input logic [1:0] b);
      logic [32:0] v_last;
      if (b != B_FIXED && b != B_INCR) return SLVERR;
      v_last = {1'b0, f_align(a, s)};
      if (b == B_INCR) v_last = v_last + ({25'd0, l} << s);
      if (a < BASE_ADDR || v_last >= LIMIT) return DECERR;
      return OKAY;
   endfunction

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   w_st_t               r_wst;
   logic                r_aw_ready, r_w_ready, r_b_valid;
   logic [1:0]          r_b_resp, r_werr, r_wburst;
   logic [ID_WIDTH-1:0] r_bid;
   logic [31:0]         r_waddr;
   logic [7:0]          r_wlen, r_wcnt;
   logic [2:0]          r_wsize;

   r_st_t                 r_rst;
   logic                  r_ar_ready, r_r_valid, r_r_last;
   logic [1:0]            r_r_resp, r_rburst;
   logic [ID_WIDTH-1:0]   r_rid;
   logic [DATA_WIDTH-1:0] r_r_data;
   logic [31:0]           r_raddr;
   logic [7:0]            r_rlen, r_rcnt;
   logic [2:0]            r_rsize;

   logic          w_wr;
   logic [IW-1:0] w_widx;
   logic [31:0]   w_ar_a0;
   logic [1:0]    w_ar_err;

   assign w_wr     = (r_wst == W_DATA) && axi.w_valid && (r_werr == OKAY);
   assign w_widx   = f_idx(r_waddr);
   assign w_ar_a0  = f_align(axi.ar_addr, axi.ar_size);
   assign w_ar_err = f_chk(axi.ar_addr, axi.ar_len,
                           axi.ar_size, axi.ar_burst);

   assign axi.aw_ready = r_aw_ready;
   assign axi.w_ready  = r_w_ready;
   assign axi.b_valid  = r_b_valid;
   assign axi.b_resp   = r_b_resp;
   assign axi.b_id     = r_bid;
   assign axi.ar_ready = r_ar_ready;
   assign axi.r_valid  = r_r_valid;
   assign axi.r_data   = r_r_data;
   assign axi.r_resp   = r_r_resp;
   assign axi.r_last   = r_r_last;
   assign axi.r_id     = r_rid;

   always_ff @(posedge aclk) begin
      if (w_wr) begin
         for (int b = 0; b < NB; b++) begin
            if (axi.w_strb[b])
               mem[w_widx][b*8 +: 8] <= axi.w_data[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wst      <= W_IDLE;
         r_aw_ready <= 1'b0;
         r_w_ready  <= 1'b0;
         r_b_valid  <= 1'b0;
         r_b_resp   <= OKAY;
         r_bid      <= '0;
         r_werr     <= OKAY;
         r_waddr    <= '0;
         r_wlen     <= '0;
         r_wcnt     <= '0;
         r_wsize    <= '0;
         r_wburst   <= '0;
      end else begin
         unique case (r_wst)
            W_IDLE: begin
               if (axi.aw_valid && r_aw_ready) begin
                  r_aw_ready <= 1'b0;
                  r_w_ready  <= 1'b1;
                  r_bid      <= axi.aw_id;
                  r_waddr    <= f_align(axi.aw_addr, axi.aw_size);
                  r_wlen     <= axi.aw_len;
                  r_wsize    <= axi.aw_size;
                  r_wburst   <= axi.aw_burst;
                  r_wcnt     <= '0;
                  r_werr     <= f_chk(axi.aw_addr, axi.aw_len,
                                      axi.aw_size, axi.aw_burst);
                  r_wst      <= W_DATA;
               end else begin
                  r_aw_ready <= 1'b1;
               end
            end
            W_DATA: begin
               if (axi.w_valid) begin
                  r_waddr <= f_next(r_waddr, r_wsize, r_wburst);
                  r_wcnt  <= r_wcnt + 8'd1;
                  if (axi.w_last) begin
                     r_w_ready <= 1'b0;
                     r_b_valid <= 1'b1;
                     r_b_resp  <= (r_werr == OKAY && r_wcnt != r_wlen)
                                  ? SLVERR : r_werr;
                     r_wst     <= W_RESP;
                  end else if (r_wcnt == r_wlen && r_werr == OKAY) begin
                     // overrun: remaining beats are drained and dropped
                     r_werr <= SLVERR;
                  end
               end
            end
            W_RESP: begin
               if (axi.b_ready) begin
                  r_b_valid  <= 1'b0;
                  r_aw_ready <= 1'b1;
                  r_wst      <= W_IDLE;
               end
            end
            default: r_wst <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rst      <= R_IDLE;
         r_ar_ready <= 1'b0;
         r_r_valid  <= 1'b0;
         r_r_last   <= 1'b0;
         r_r_resp   <= OKAY;
         r_r_data   <= '0;
         r_rid      <= '0;
         r_raddr    <= '0;
         r_rlen     <= '0;
         r_rcnt     <= '0;
         r_rsize    <= '0;
         r_rburst   <= '0;
      end else begin
         unique case (r_rst)
            R_IDLE: begin
               if (axi.ar_valid && r_ar_ready) begin
                  r_ar_ready <= 1'b0;
                  r_r_valid  <= 1'b1;
                  r_rid      <= axi.ar_id;
                  r_r_resp   <= w_ar_err;
                  r_r_data   <= (w_ar_err == OKAY)
                                ? mem[f_idx(w_ar_a0)] : '0;
                  r_r_last   <= (axi.ar_len == 8'd0);
                  r_raddr    <= f_next(w_ar_a0, axi.ar_size,
                                       axi.ar_burst);
                  r_rlen     <= axi.ar_len;
                  r_rsize    <= axi.ar_size;
                  r_rburst   <= axi.ar_burst;
                  r_rcnt     <= '0;
                  r_rst      <= R_DATA;
               end else begin
                  r_ar_ready <= 1'b1;
               end
            end
            R_DATA: begin
               if (axi.r_ready) begin
                  if (r_r_last) begin
                     r_r_valid  <= 1'b0;
                     r_ar_ready <= 1'b1;
                     r_rst      <= R_IDLE;
                  end else begin
                     r_r_data <= (r_r_resp == OKAY)
                                 ? mem[f_idx(r_raddr)] : '0;
                     r_raddr  <= f_next(r_raddr, r_rsize, r_rburst);
                     r_rcnt   <= r_rcnt + 8'd1;
                     r_r_last <= (r_rcnt + 8'd1 == r_rlen);
                  end
               end
            end
            default: r_rst <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: single-beat vector table plus
// hand-written burst, stall, error, collision and reset sequences.
module tb_axi4_sram_slave;
   localparam int          DW   = 128;
   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam logic [31:0] SZ   = 32'd4096;
   localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
   localparam logic [1:0]  FIX = 2'b00, INC = 2'b01, WRP = 2'b10;
   localparam int S_AW = 0, S_W = 1, S_B = 2, S_AR = 3;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   axi4_sram_if #(.DATA_WIDTH(DW), .ID_WIDTH(4)) axi ();

   axi4_sram_slave #(
      .DATA_WIDTH(DW), .ID_WIDTH(4),
      .BASE_ADDR(BASE), .MEM_WORDS(256)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .axi(axi)
   );

   int n_chk = 0;
   int n_fail = 0;
   int n_unst = 0;

   logic [DW-1:0] wbuf [16];
   logic [DW-1:0] rbuf [16];
   logic [1:0]    rrsp [16];
   logic          rlst [16];
   logic [3:0]    rids [16];

   typedef struct {
      string       nm;
      logic [31:0] addr;
      logic [1:0]  burst;
      logic [DW-1:0] wdata;
      logic [1:0]  exp_b;
      logic [DW-1:0] exp_r;
      logic [1:0]  exp_rr;
   } vec_t;
   vec_t vt [6];

   task automatic chk(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         S_AW:    return axi.aw_ready;
         S_W:     return axi.w_ready;
         S_B:     return axi.b_valid;
         default: return axi.ar_ready;
      endcase
   endfunction

   task automatic wait_hi(input int sel, input string nm);
      int t = 0;
      while (sig(sel) !== 1'b1 && t < 100) begin
         @(posedge aclk); #1; t++;
      end
      if (t >= 100) begin
         n_chk++; n_fail++;
         $display("FAIL %s timeout: got 0 expected 1", nm);
      end
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst,
                           input logic [15:0] strb, input int nb,
                           output logic [1:0] resp, output logic [3:0] bid);
      axi.aw_id = id; axi.aw_addr = addr; axi.aw_len = len;
      axi.aw_size = 3'd4; axi.aw_burst = burst; axi.aw_valid = 1'b1;
      wait_hi(S_AW, "aw_ready");
      @(posedge aclk); #1;
      axi.aw_valid = 1'b0;
      for (int i = 0; i < nb; i++) begin
         axi.w_data = wbuf[i]; axi.w_strb = strb;
         axi.w_last = (i == nb - 1); axi.w_valid = 1'b1;
         wait_hi(S_W, "w_ready");
         @(posedge aclk); #1;
      end
      axi.w_valid = 1'b0; axi.w_last = 1'b0; axi.b_ready = 1'b1;
      wait_hi(S_B, "b_valid");
      resp = axi.b_resp; bid = axi.b_id;
      @(posedge aclk); #1;
      axi.b_ready = 1'b0;
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] pat, output int nb);
      int g = 0;
      logic held = 1'b0;
      logic [DW-1:0] hd = '0;
      logic hl = 1'b0;
      nb = 0;
      axi.ar_id = id; axi.ar_addr = addr; axi.ar_len = len;
      axi.ar_size = 3'd4; axi.ar_burst = burst; axi.ar_valid = 1'b1;
      wait_hi(S_AR, "ar_ready");
      @(posedge aclk); #1;
      axi.ar_valid = 1'b0;
      chk("r_valid 1 cycle after AR", axi.r_valid, 1);
      while (nb <= int'(len) && g < 300) begin
         axi.r_ready = pat[g % 4];
         if (axi.r_valid && axi.r_ready) begin
            rbuf[nb] = axi.r_data; rrsp[nb] = axi.r_resp;
            rlst[nb] = axi.r_last; rids[nb] = axi.r_id;
            nb++; held = 1'b0;
         end else if (axi.r_valid) begin
            held = 1'b1; hd = axi.r_data; hl = axi.r_last;
         end
         @(posedge aclk); #1; g++;
         if (held && (axi.r_data !== hd || axi.r_last !== hl ||
                      axi.r_valid !== 1'b1))
            n_unst++;
      end
      axi.r_ready = 1'b0;
      if (nb <= int'(len)) begin
         n_chk++; n_fail++;
         $display("FAIL read beats timeout: got %0d expected %0d",
                  nb, int'(len) + 1);
      end
      chk("r_valid low after last", axi.r_valid, 0);
   endtask

   initial begin
      logic [1:0] resp;
      logic [3:0] bid;
      int nb, nlast, cnt;
      logic [DW-1:0] r0, r1, r2, oldv, newv;
      logic l2;

      axi.aw_valid = 0; axi.aw_id = 0; axi.aw_addr = 0; axi.aw_len = 0;
      axi.aw_size = 0; axi.aw_burst = 0;
      axi.w_valid = 0; axi.w_data = 0; axi.w_strb = 0; axi.w_last = 0;
      axi.b_ready = 0;
      axi.ar_valid = 0; axi.ar_id = 0; axi.ar_addr = 0; axi.ar_len = 0;
      axi.ar_size = 0; axi.ar_burst = 0; axi.r_ready = 0;

      vt[0] = '{"first word", BASE, INC, {4{32'h0123_4567}},
                OKAY, {4{32'h0123_4567}}, OKAY};
      vt[1] = '{"last word", BASE + SZ - 16, INC, {4{32'h89AB_CDEF}},
                OKAY, {4{32'h89AB_CDEF}}, OKAY};
      vt[2] = '{"above top", BASE + SZ, INC, {4{32'h1111_2222}},
                DECERR, '0, DECERR};
      vt[3] = '{"below base", BASE - 16, INC, {4{32'h3333_4444}},
                DECERR, '0, DECERR};
      vt[4] = '{"wrap burst", BASE + 32'h40, WRP, {4{32'h5555_6666}},
                SLVERR, '0, SLVERR};
      vt[5] = '{"fixed burst", BASE + 32'h50, FIX, {4{32'h7777_8888}},
                OKAY, {4{32'h7777_8888}}, OKAY};

      // reset held 5 cycles
      repeat (5) @(posedge aclk);
      #1;
      chk("reset ready/valid",
          {axi.aw_ready, axi.w_ready, axi.b_valid,
           axi.ar_ready, axi.r_valid}, 0);
      chk("reset resp/id",
          {axi.b_resp, axi.r_resp, axi.b_id, axi.r_id, axi.r_last}, 0);
      chk("reset rdata", axi.r_data, 0);
      aresetn = 1'b1;
      @(posedge aclk); #1;
      chk("aw/ar ready after reset", {axi.aw_ready, axi.ar_ready}, 2'b11);

      for (int v = 0; v < 6; v++) begin
         wbuf[0] = vt[v].wdata;
         do_write(4'h1, vt[v].addr, 8'd0, vt[v].burst, 16'hFFFF, 1,
                  resp, bid);
         chk({vt[v].nm, " bresp"}, resp, vt[v].exp_b);
         do_read(4'h2, vt[v].addr, 8'd0, vt[v].burst, 4'b1111, nb);
         chk({vt[v].nm, " rdata"}, rbuf[0], vt[v].exp_r);
         chk({vt[v].nm, " rresp"}, rrsp[0], vt[v].exp_rr);
      end
      do_read(4'h2, BASE + SZ - 16, 8'd0, INC, 4'b1111, nb);
      chk("last word kept after below-base write", rbuf[0],
          {4{32'h89AB_CDEF}});

      // INCR burst write / read-back
      for (int i = 0; i < 4; i++)
         wbuf[i] = {32'h5724_0000 + i, 32'hA5A5_0000 + i,
                    32'h0F0F_0000 + i, 32'h5724_5724 ^ i};
      do_write(4'hA, BASE + 32'h100, 8'd3, INC, 16'hFFFF, 4, resp, bid);
      chk("burst bresp", resp, OKAY);
      chk("burst bid", bid, 4'hA);
      do_read(4'h6, BASE + 32'h100, 8'd3, INC, 4'b1111, nb);
      nlast = 0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("burst rdata %0d", i), rbuf[i], wbuf[i]);
         nlast += int'(rlst[i]);
      end
      chk("burst rlast on beat 3", rlst[3], 1);
      chk("burst rlast count", nlast, 1);
      chk("burst rid", rids[0], 4'h6);

      // len=7 read with r_ready stalls
      for (int i = 0; i < 8; i++)
         wbuf[i] = {4{32'hC0DE_0000 + i * 32'h111}};
      do_write(4'h3, BASE + 32'h200, 8'd7, INC, 16'hFFFF, 8, resp, bid);
      chk("len7 bresp", resp, OKAY);
      n_unst = 0;
      do_read(4'h3, BASE + 32'h200, 8'd7, INC, 4'b1001, nb);
      nlast = 0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("stall rdata %0d", i), rbuf[i], wbuf[i]);
         nlast += int'(rlst[i]);
      end
      chk("stall rlast count", nlast, 1);
      chk("stall rlast position", rlst[7], 1);
      chk("rdata stable during stalls", n_unst, 0);

      // out-of-range write aliases word 0; read crossing the top
      wbuf[0] = {4{32'hDEAD_BEEF}};
      do_write(4'h4, 32'h0F00_0000, 8'd0, INC, 16'hFFFF, 1, resp, bid);
      chk("below base bresp", resp, DECERR);
      do_read(4'h4, BASE, 8'd0, INC, 4'b1111, nb);
      chk("word 0 unchanged", rbuf[0], {4{32'h0123_4567}});
      do_read(4'h5, BASE + SZ - 16, 8'd1, INC, 4'b1111, nb);
      chk("top read beats", nb, 2);
      chk("top rresp 0", rrsp[0], DECERR);
      chk("top rresp 1", rrsp[1], DECERR);
      chk("top rdata 0", rbuf[0], 0);
      chk("top rdata 1", rbuf[1], 0);
      chk("top rlast", {rlst[0], rlst[1]}, 2'b01);

      // partial strobe over background, protocol errors
      wbuf[0] = {16{8'hAA}};
      do_write(4'h1, BASE + 32'h300, 8'd0, INC, 16'hFFFF, 1, resp, bid);
      wbuf[0] = {16{8'h11}};
      do_write(4'h1, BASE + 32'h300, 8'd0, INC, 16'h00FF, 1, resp, bid);
      chk("strobe bresp", resp, OKAY);
      do_read(4'h1, BASE + 32'h300, 8'd0, INC, 4'b1111, nb);
      chk("strobe rdata", rbuf[0], {{8{8'hAA}}, {8{8'h11}}});
      do_write(4'h7, BASE + 32'h310, 8'd1, INC, 16'hFFFF, 1, resp, bid);
      chk("early last bresp", resp, SLVERR);
      chk("early last bid", bid, 4'h7);
      wbuf[1] = {16{8'h22}};
      do_write(4'h7, BASE + 32'h320, 8'd0, INC, 16'hFFFF, 2, resp, bid);
      chk("overrun bresp", resp, SLVERR);

      // AW and AR to one word in the same cycle
      oldv = {4{32'h0000_01D0}};
      newv = {4{32'h0000_0E77}};
      wbuf[0] = oldv;
      do_write(4'h1, BASE + 32'h400, 8'd0, INC, 16'hFFFF, 1, resp, bid);
      chk("collision ready", {axi.aw_ready, axi.ar_ready}, 2'b11);
      axi.aw_id = 4'h3; axi.aw_addr = BASE + 32'h400; axi.aw_len = 0;
      axi.aw_size = 3'd4; axi.aw_burst = INC; axi.aw_valid = 1'b1;
      axi.ar_id = 4'h5; axi.ar_addr = BASE + 32'h400; axi.ar_len = 2;
      axi.ar_size = 3'd4; axi.ar_burst = FIX; axi.ar_valid = 1'b1;
      @(posedge aclk); #1;
      axi.aw_valid = 1'b0; axi.ar_valid = 1'b0;
      r0 = axi.r_data;
      axi.w_data = newv; axi.w_strb = 16'hFFFF; axi.w_last = 1'b1;
      axi.w_valid = 1'b1; axi.r_ready = 1'b1;
      @(posedge aclk); #1;
      axi.w_valid = 1'b0; axi.w_last = 1'b0;
      r1 = axi.r_data;
      @(posedge aclk); #1;
      r2 = axi.r_data; l2 = axi.r_last;
      @(posedge aclk); #1;
      axi.r_ready = 1'b0;
      chk("collision beat 0 old", r0, oldv);
      chk("collision beat 1 same-cycle old", r1, oldv);
      chk("collision beat 2 new", r2, newv);
      chk("collision rlast", l2, 1);
      chk("collision r done", axi.r_valid, 0);
      axi.b_ready = 1'b1;
      wait_hi(S_B, "collision b_valid");
      chk("collision bresp", axi.b_resp, OKAY);
      chk("collision bid", axi.b_id, 4'h3);
      @(posedge aclk); #1;
      axi.b_ready = 1'b0;
      do_read(4'h1, BASE + 32'h400, 8'd0, INC, 4'b1111, nb);
      chk("collision later read new", rbuf[0], newv);

      // reset during beat 2 of a len=3 read
      axi.ar_id = 4'h9; axi.ar_addr = BASE + 32'h100; axi.ar_len = 3;
      axi.ar_size = 3'd4; axi.ar_burst = INC; axi.ar_valid = 1'b1;
      wait_hi(S_AR, "ar_ready before reset");
      @(posedge aclk); #1;
      axi.ar_valid = 1'b0; axi.r_ready = 1'b1;
      repeat (2) begin @(posedge aclk); #1; end
      chk("beat 2 valid before reset", axi.r_valid, 1);
      aresetn = 1'b0;
      #1;
      chk("reset clears r_valid at once",
          {axi.r_valid, axi.ar_ready, axi.r_last}, 0);
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge aclk); #1;
         cnt += int'(axi.r_valid);
      end
      axi.r_ready = 1'b0;
      chk("no R after reset", cnt, 0);
      chk("idle after reset", {axi.aw_ready, axi.ar_ready}, 2'b11);
      do_read(4'h2, BASE + 32'h100, 8'd3, INC, 4'b1111, nb);
      chk("data kept across reset 0", rbuf[0],
          {32'h5724_0000, 32'hA5A5_0000, 32'h0F0F_0000, 32'h5724_5724});
      chk("data kept across reset 3", rbuf[3],
          {32'h5724_0003, 32'hA5A5_0003, 32'h0F0F_0003, 32'h5724_5727});

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
